// File: rtl/taillight_controller.sv
// Six-lamp tail-light sequencer: arbitrates left/right/hazard requests into one
// animated pattern paced by a step prescaler, with a registered brake overlay.
module taillight_controller #(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Rs,
  input  logic L,
  input  logic R,
  input  logic Haz,
  input  logic Brk,
  output logic LA,
  output logic LB,
  output logic LC,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic Busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] cnt_r;
  logic          brk_q;
  logic          tick_s;
  logic [2:0]    left_s;
  logic [2:0]    right_s;

  assign tick_s = (cnt_r == CNT_LAST);

  // State, prescaler and brake registers; Rs wins over everything.
  always_ff @(posedge Clk) begin
    if (Rs) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      brk_q   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      brk_q   <= Brk;
      if (tick_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; requests are only looked at on tick edges.
  always_comb begin
    next_state_s = state_r;
    if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (Haz || (L && R)) begin
            next_state_s = HAZ;
          end else if (L) begin
            next_state_s = L1;
          end else if (R) begin
            next_state_s = R1;
          end else begin
            next_state_s = IDLE;
          end
        end
        L1:      next_state_s = Haz ? HAZ : L2;
        L2:      next_state_s = Haz ? HAZ : L3;
        L3:      next_state_s = Haz ? HAZ : IDLE;
        R1:      next_state_s = Haz ? HAZ : R2;
        R2:      next_state_s = Haz ? HAZ : R3;
        R3:      next_state_s = Haz ? HAZ : IDLE;
        HAZ:     next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Lamp decode from registered state and brake only; brake fills the idle side.
  always_comb begin
    left_s  = 3'b000;
    right_s = 3'b000;
    case (state_r)
      IDLE:    begin left_s = 3'b000; right_s = 3'b000; end
      L1:      left_s  = 3'b100;
      L2:      left_s  = 3'b110;
      L3:      left_s  = 3'b111;
      R1:      right_s = 3'b100;
      R2:      right_s = 3'b110;
      R3:      right_s = 3'b111;
      HAZ:     begin left_s = 3'b111; right_s = 3'b111; end
      default: begin left_s = 3'b000; right_s = 3'b000; end
    endcase
    if (brk_q) begin
      if ((state_r != L1) && (state_r != L2) && (state_r != L3)) begin
        left_s = 3'b111;
      end else begin
        left_s = left_s;
      end
      if ((state_r != R1) && (state_r != R2) && (state_r != R3)) begin
        right_s = 3'b111;
      end else begin
        right_s = right_s;
      end
    end else begin
      left_s  = left_s;
      right_s = right_s;
    end
  end

  assign {LA, LB, LC} = left_s;
  assign {RA, RB, RC} = right_s;
  assign Busy         = (state_r != IDLE);

endmodule

// File: tb/tb_taillight_controller.sv
// Directed bench for taillight_controller: DIV=4 instance for the main scenarios,
// DIV=1 instance for the every-cycle stepping case.
module tb_taillight_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rs, l, r, haz, brk;
  logic la, lb, lc, ra, rb, rc, busy;
  logic rs1, l_1;
  logic la1, lb1, lc1, ra1, rb1, rc1, busy1;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  taillight_controller #(.DIV(4)) dut (
    .Clk(clk), .Rs(rs), .L(l), .R(r), .Haz(haz), .Brk(brk),
    .LA(la), .LB(lb), .LC(lc), .RA(ra), .RB(rb), .RC(rc), .Busy(busy)
  );

  taillight_controller #(.DIV(1)) dut1 (
    .Clk(clk), .Rs(rs1), .L(l_1), .R(1'b0), .Haz(1'b0), .Brk(1'b0),
    .LA(la1), .LB(lb1), .LC(lc1), .RA(ra1), .RB(rb1), .RC(rc1), .Busy(busy1)
  );

  // Observed word is {Busy, LA, LB, LC, RA, RB, RC}.
  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [6:0] obs4();
    return {busy, la, lb, lc, ra, rb, rc};
  endfunction

  function automatic logic [6:0] obs1();
    return {busy1, la1, lb1, lc1, ra1, rb1, rc1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  initial begin
    rs = 1'b1; l = 1'b0; r = 1'b0; haz = 1'b0; brk = 1'b0;
    rs1 = 1'b1; l_1 = 1'b0;
    step(); step();
    check("reset", obs4(), 7'b0_000000);

    // Left sequence, L held from release; edges counted from release.
    rs = 1'b0; l = 1'b1; edge_n = 0;
    run_to(3);  check("left_e3",  obs4(), 7'b0_000000);
    run_to(4);  check("left_e4",  obs4(), 7'b1_100000);
    run_to(7);  check("left_e7",  obs4(), 7'b1_100000);
    run_to(8);  check("left_e8",  obs4(), 7'b1_110000);
    run_to(12); check("left_e12", obs4(), 7'b1_111000);
    run_to(15); check("left_e15", obs4(), 7'b1_111000);
    run_to(16); check("left_e16", obs4(), 7'b0_000000);
    run_to(19); check("left_e19", obs4(), 7'b0_000000);
    run_to(20); check("left_e20", obs4(), 7'b1_100000);

    // Hazard from L2, then blink with Haz held.
    run_to(24); check("l2_e24", obs4(), 7'b1_110000);
    haz = 1'b1;
    run_to(28); check("haz_on",    obs4(), 7'b1_111111);
    run_to(31); check("haz_hold",  obs4(), 7'b1_111111);
    run_to(32); check("haz_off",   obs4(), 7'b0_000000);
    run_to(35); check("haz_off_h", obs4(), 7'b0_000000);
    run_to(36); check("haz_on2",   obs4(), 7'b1_111111);
    haz = 1'b0; l = 1'b1; r = 1'b1;
    run_to(40); check("haz_idle",  obs4(), 7'b0_000000);
    run_to(44); check("lr_haz",    obs4(), 7'b1_111111);
    l = 1'b0; r = 1'b0;
    run_to(48); check("lr_off",    obs4(), 7'b0_000000);
    run_to(52); check("idle_e52",  obs4(), 7'b0_000000);

    // No early abort: R starts, then L replaces it.
    r = 1'b1;
    run_to(56); check("r1",        obs4(), 7'b1_000100);
    r = 1'b0; l = 1'b1;
    run_to(60); check("r2",        obs4(), 7'b1_000110);
    run_to(64); check("r3",        obs4(), 7'b1_000111);
    run_to(68); check("r_done",    obs4(), 7'b0_000000);
    run_to(72); check("l1_after",  obs4(), 7'b1_100000);
    l = 1'b0;
    run_to(84); check("idle_e84",  obs4(), 7'b0_000000);

    // Brake during R2, then brake with hazard.
    r = 1'b1;
    run_to(88); check("r1_b",      obs4(), 7'b1_000100);
    r = 1'b0;
    run_to(92); check("r2_b",      obs4(), 7'b1_000110);
    brk = 1'b1;
    run_to(93); check("brk_r2",    obs4(), 7'b1_111110);
    run_to(96); check("brk_r3",    obs4(), 7'b1_111111);
    run_to(100); check("brk_idle", obs4(), 7'b0_111111);
    haz = 1'b1;
    run_to(104); check("brk_haz",   obs4(), 7'b1_111111);
    run_to(108); check("brk_hazi",  obs4(), 7'b0_111111);
    run_to(118); check("brk_haz2",  obs4(), 7'b0_111111);
    run_to(121); check("brk_haz3",  obs4(), 7'b1_111111);
    run_to(124); haz = 1'b0;
    run_to(125); check("brk_pre",   obs4(), 7'b0_111111);
    brk = 1'b0;
    run_to(126); check("brk_drop",  obs4(), 7'b0_000000);

    // Reset in L3 with cnt=2.
    l = 1'b1;
    run_to(128); check("l1_rst",   obs4(), 7'b1_100000);
    run_to(138); check("l3_rst",   obs4(), 7'b1_111000);
    rs = 1'b1;
    run_to(139); check("mid_rst",  obs4(), 7'b0_000000);
    rs = 1'b0; edge_n = 0;
    run_to(3);  check("rel_e3",    obs4(), 7'b0_000000);
    run_to(4);  check("rel_e4",    obs4(), 7'b1_100000);

    // Haz pulse while cnt=1 must be missed.
    run_to(5); haz = 1'b1;
    run_to(6); haz = 1'b0;
    check("pulse_e6", obs4(), 7'b1_100000);
    run_to(8); check("pulse_e8",  obs4(), 7'b1_110000);

    // DIV=1: a step on every edge.
    check("d1_reset", obs1(), 7'b0_000000);
    rs1 = 1'b0; l_1 = 1'b1; edge_n = 0;
    run_to(1); check("d1_e1", obs1(), 7'b1_100000);
    run_to(2); check("d1_e2", obs1(), 7'b1_110000);
    run_to(3); check("d1_e3", obs1(), 7'b1_111000);
    run_to(4); check("d1_e4", obs1(), 7'b0_000000);
    run_to(5); check("d1_e5", obs1(), 7'b1_100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taillight_controller.md
# taillight_controller

Sequencing controller for the Thunderbird-style six-lamp tail-light bank (LA/LB/LC left, RA/RB/RC right). It decides which lamp pattern is shown and when it advances. Left, right, hazard and brake requests are arbitrated into a single lamp pattern, and the animation is paced by an internal step prescaler rather than the raw clock. It sits between the driver switch inputs and the lamp drivers, replacing direct clock-rate sequencing.

## Interface
- DIV, default 4: clock cycles per animation step, DIV >= 1. DIV = 1 steps every cycle.
- Clk  in  1  system clock; all state changes on the rising edge.
- Rs  in  1  reset; synchronous, active-high.
- L  in  1  left-turn request, level.
- R  in  1  right-turn request, level.
- Haz  in  1  hazard request, level.
- Brk  in  1  brake request, level.
- LA, LB, LC  out  1 each  left lamps; LA is innermost.
- RA, RB, RC  out  1 each  right lamps; RA is innermost.
- Busy  out  1  high when the FSM is not in IDLE.

## Operation
- Prescaler:
  - cnt is ceil(log2(DIV)) bits wide, minimum 1 bit.
  - cnt increments every cycle and wraps DIV-1 -> 0.
  - tick = (cnt == DIV-1).
- FSM states and Moore lamp patterns:
  - IDLE: none.
  - L1: LA. L2: LA, LB. L3: LA, LB, LC.
  - R1: RA. R2: RA, RB. R3: RA, RB, RC.
  - HAZ: all six lamps.
- Transitions happen only on edges where tick = 1. Otherwise the state holds.
  - IDLE: Haz or (L & R) -> HAZ; else L -> L1; else R -> R1; else stay in IDLE.
  - Ln: Haz -> HAZ; else L1 -> L2 -> L3 -> IDLE.
  - Rn: Haz -> HAZ; else R1 -> R2 -> R3 -> IDLE.
  - HAZ: always -> IDLE. A held Haz therefore blinks HAZ/IDLE, one step each.
- A started turn sequence runs to completion; dropping L or R mid-sequence does not abort it.
  - Only Haz aborts a sequence.
  - The opposite-side request is ignored until the FSM returns to IDLE.
- L, R and Haz are sampled only at tick edges. Pulses that fall entirely between ticks are lost (intended behaviour).
- Brake:
  - Brk is registered every cycle into brk_q, independent of tick.
  - When brk_q = 1, each side that is not currently animating shows all three lamps.
    - Left override applies in IDLE, R1-R3 and HAZ.
    - Right override applies in IDLE, L1-L3 and HAZ.
  - The animating side shows its FSM pattern unchanged.
  - In HAZ, brake makes both sides steady-on; the blink is masked.
- Outputs are a combinational decode of (state, brk_q) only. No input reaches an output without passing through a register.
- Reset values: state IDLE, cnt 0, brk_q 0, all lamps 0, Busy 0.

## Timing
- Rs is sampled at the rising edge. Reset takes priority over all other inputs.
- Reset mid-sequence: lamps and Busy are 0 after that edge, and the prescaler restarts from 0.
- First cycle after Rs deasserts: cnt = 0. The first tick edge is the DIV-th rising edge after release.
- With L held from reset release and DIV = D, counting rising edges after release:
  - LA from edge D.
  - LB from edge 2D.
  - LC from edge 3D.
  - All off at edge 4D.
  - L1 again at edge 5D if L is still held.
- Brake latency is one cycle: lamps respond at the edge after Brk changes. This holds in every state and at every cnt value.
- Busy rises and falls on the same edges as the state change.
- Simultaneous events at a tick:
  - Haz beats L and R.
  - L & R together counts as hazard.
  - Haz arriving in L3 or R3 goes to HAZ, not IDLE.

## Test plan
- Left sequence: DIV=4; Rs high 2 cycles, then L=1 held → LA at edge 4; LA,LB at 8; LA,LB,LC at 12; all 0 at 16; LA at 20; Busy=0 only in cycles 16-19.
- No early abort: R=1 for one tick to start R1, then R=0 and L=1 → R2 and R3 still follow; L1 is entered only at the tick after R3→IDLE.
- Hazard: from L2, assert Haz at the next tick → all six on for 4 cycles, all off for 4 cycles, repeating. L=1,R=1 with Haz=0 gives the same pattern.
- Brake: in R2 raise Brk → next edge LA,LB,LC=1 while RA,RB=1,RC=0 continues animating. In HAZ with Brk=1 → all six steady for 16+ cycles. Drop Brk → left side off at the next edge.
- Reset mid-operation: Rs=1 during L3 with cnt=2 → all outputs 0 and Busy 0 after that edge. After release with L held, LA appears exactly DIV edges later.
- DIV=1: L held → LA, LA+LB, LA+LB+LC, off on consecutive edges. A 1-cycle Haz pulse between ticks at DIV=4 (cnt=1) is ignored.
